// File: rtl/port_alloc_pipe_pkg.sv
// Shared defaults, pick encoding and the highest-bit priority encoder for the
// deflection-router port allocator.
package port_alloc_pipe_pkg;

  localparam int DEF_NUM_PORT   = 5;
  localparam int DEF_NUM_FLIT   = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_PORT_VEC_W = DEF_NUM_FLIT * DEF_NUM_PORT;

  localparam int MAX_PORT   = 32;
  localparam int PORT_IDX_W = 5;

  typedef enum logic [1:0] {
    PICK_IDLE,
    PICK_PROD,
    PICK_DEFL,
    PICK_NONE
  } pick_e;

  function automatic logic [PORT_IDX_W-1:0] hi_bit_idx(input logic [MAX_PORT-1:0] v);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORT; i++) begin
      if (v[i]) idx = PORT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/port_alloc_pipe_if.sv
// Batch request / grant bundle between the router core and the port allocator.
interface port_alloc_pipe_if
  import port_alloc_pipe_pkg::*;
#(
  parameter int NUM_PORT = DEF_NUM_PORT,
  parameter int NUM_FLIT = DEF_NUM_FLIT,
  parameter int CNT_W    = DEF_CNT_W
);

  logic                         in_valid;
  logic [NUM_FLIT-1:0]          in_flit_vld;
  logic [NUM_FLIT*NUM_PORT-1:0] in_req;
  logic [NUM_PORT-1:0]          in_avail;
  logic                         cnt_clr;
  logic                         out_valid;
  logic [NUM_FLIT*NUM_PORT-1:0] out_alloc;
  logic [NUM_FLIT-1:0]          out_deflect;
  logic [NUM_FLIT-1:0]          out_nogrant;
  logic [CNT_W-1:0]             deflect_cnt;

  modport master (
    output in_valid, in_flit_vld, in_req, in_avail, cnt_clr,
    input  out_valid, out_alloc, out_deflect, out_nogrant, deflect_cnt
  );

  modport slave (
    input  in_valid, in_flit_vld, in_req, in_avail, cnt_clr,
    output out_valid, out_alloc, out_deflect, out_nogrant, deflect_cnt
  );

endinterface

// File: rtl/port_alloc_pipe_stage.sv
// One allocation stage: grants flit IDX a productive or round-robin deflection
// port and registers the whole batch state for the next stage.
module port_alloc_stage
  import port_alloc_pipe_pkg::*;
#(
  parameter int NUM_PORT = DEF_NUM_PORT,
  parameter int NUM_FLIT = DEF_NUM_FLIT,
  parameter int IDX      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cur_vld,
  input  logic [NUM_FLIT-1:0]          cur_fvld,
  input  logic [NUM_FLIT*NUM_PORT-1:0] cur_req,
  input  logic [NUM_PORT-1:0]          cur_avail,
  input  logic [NUM_FLIT*NUM_PORT-1:0] cur_alloc,
  input  logic [NUM_FLIT-1:0]          cur_deflect,
  input  logic [NUM_FLIT-1:0]          cur_nogrant,
  output logic                         nxt_vld,
  output logic [NUM_FLIT-1:0]          nxt_fvld,
  output logic [NUM_FLIT*NUM_PORT-1:0] nxt_req,
  output logic [NUM_PORT-1:0]          nxt_avail,
  output logic [NUM_FLIT*NUM_PORT-1:0] nxt_alloc,
  output logic [NUM_FLIT-1:0]          nxt_deflect,
  output logic [NUM_FLIT-1:0]          nxt_nogrant
);

  localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [PTR_W-1:0]             ptr;
  logic [PTR_W-1:0]             rr_idx;
  logic [PTR_W-1:0]             ptr_next;
  logic [NUM_PORT-1:0]          my_req;
  logic [NUM_PORT-1:0]          prod;
  logic [NUM_PORT-1:0]          hi_pick;
  logic [NUM_PORT-1:0]          rr_pick;
  logic [NUM_PORT-1:0]          grant;
  logic [NUM_FLIT*NUM_PORT-1:0] alloc_upd;
  logic [NUM_FLIT-1:0]          deflect_upd;
  logic [NUM_FLIT-1:0]          nogrant_upd;
  pick_e                        pick;

  assign my_req  = cur_req[IDX*NUM_PORT +: NUM_PORT];
  assign prod    = my_req & cur_avail;
  assign hi_pick = NUM_PORT'(1) << hi_bit_idx(MAX_PORT'(prod));

  // Scan upward from ptr with wrap; the first free port wins.
  always_comb begin : rr_scan
    int   p;
    logic found;
    found  = 1'b0;
    rr_idx = ptr;
    p      = 0;
    for (int j = 0; j < NUM_PORT; j++) begin
      p = int'(ptr) + j;
      if (p >= NUM_PORT) p = p - NUM_PORT;
      if (!found && cur_avail[p]) begin
        found  = 1'b1;
        rr_idx = PTR_W'(p);
      end
    end
  end

  assign rr_pick  = NUM_PORT'(1) << rr_idx;
  assign ptr_next = (rr_idx == PTR_W'(NUM_PORT-1)) ? '0 : rr_idx + 1'b1;

  always_comb begin
    pick  = PICK_IDLE;
    grant = '0;
    if (cur_vld && cur_fvld[IDX]) begin
      if (|prod) begin
        pick  = PICK_PROD;
        grant = hi_pick;
      end else if (|cur_avail) begin
        pick  = PICK_DEFL;
        grant = rr_pick;
      end else begin
        pick  = PICK_NONE;
      end
    end
  end

  always_comb begin
    alloc_upd                                = cur_alloc;
    alloc_upd[IDX*NUM_PORT +: NUM_PORT]      = grant;
    deflect_upd                              = cur_deflect;
    deflect_upd[IDX]                         = (pick == PICK_DEFL);
    nogrant_upd                              = cur_nogrant;
    nogrant_upd[IDX]                         = (pick == PICK_NONE);
  end

  // Stage boundary: batch state handed to stage IDX+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      nxt_vld     <= 1'b0;
      nxt_fvld    <= '0;
      nxt_req     <= '0;
      nxt_avail   <= '0;
      nxt_alloc   <= '0;
      nxt_deflect <= '0;
      nxt_nogrant <= '0;
    end else begin
      nxt_vld     <= cur_vld;
      nxt_fvld    <= cur_fvld;
      nxt_req     <= cur_req;
      nxt_avail   <= cur_avail & ~grant;
      nxt_alloc   <= alloc_upd;
      nxt_deflect <= deflect_upd;
      nxt_nogrant <= nogrant_upd;
      if (pick == PICK_DEFL) ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/port_alloc_pipe.sv
// Pipelined last-stage port allocator: input register, NUM_FLIT allocation
// stages, and a saturating deflection counter on the registered outputs.
module port_alloc_pipe
  import port_alloc_pipe_pkg::*;
#(
  parameter int NUM_PORT = DEF_NUM_PORT,
  parameter int NUM_FLIT = DEF_NUM_FLIT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset,
  port_alloc_pipe_if.slave bus
);

  localparam int SUM_W = CNT_W + $clog2(NUM_FLIT + 1) + 1;

  logic                         vld_p0;
  logic [NUM_FLIT-1:0]          fvld_p0;
  logic [NUM_FLIT*NUM_PORT-1:0] req_p0;
  logic [NUM_PORT-1:0]          avail_p0;

  logic                         c_vld     [NUM_FLIT+1];
  logic [NUM_FLIT-1:0]          c_fvld    [NUM_FLIT+1];
  logic [NUM_FLIT*NUM_PORT-1:0] c_req     [NUM_FLIT+1];
  logic [NUM_PORT-1:0]          c_avail   [NUM_FLIT+1];
  logic [NUM_FLIT*NUM_PORT-1:0] c_alloc   [NUM_FLIT+1];
  logic [NUM_FLIT-1:0]          c_deflect [NUM_FLIT+1];
  logic [NUM_FLIT-1:0]          c_nogrant [NUM_FLIT+1];

  logic [CNT_W-1:0]             cnt;

  function automatic int unsigned popcount(input logic [NUM_FLIT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_FLIT; i++) n = n + int'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  // Input boundary: batch sampled into p0; only the valid needs a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p0 <= 1'b0;
    else        vld_p0 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    fvld_p0  <= bus.in_flit_vld;
    req_p0   <= bus.in_req;
    avail_p0 <= bus.in_avail;
  end

  assign c_vld[0]     = vld_p0;
  assign c_fvld[0]    = fvld_p0;
  assign c_req[0]     = req_p0;
  assign c_avail[0]   = avail_p0;
  assign c_alloc[0]   = '0;
  assign c_deflect[0] = '0;
  assign c_nogrant[0] = '0;

  for (genvar k = 0; k < NUM_FLIT; k++) begin : g_stage
    port_alloc_stage #(
      .NUM_PORT (NUM_PORT),
      .NUM_FLIT (NUM_FLIT),
      .IDX      (k)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .cur_vld     (c_vld[k]),
      .cur_fvld    (c_fvld[k]),
      .cur_req     (c_req[k]),
      .cur_avail   (c_avail[k]),
      .cur_alloc   (c_alloc[k]),
      .cur_deflect (c_deflect[k]),
      .cur_nogrant (c_nogrant[k]),
      .nxt_vld     (c_vld[k+1]),
      .nxt_fvld    (c_fvld[k+1]),
      .nxt_req     (c_req[k+1]),
      .nxt_avail   (c_avail[k+1]),
      .nxt_alloc   (c_alloc[k+1]),
      .nxt_deflect (c_deflect[k+1]),
      .nxt_nogrant (c_nogrant[k+1])
    );
  end

  assign bus.out_valid   = c_vld[NUM_FLIT];
  assign bus.out_alloc   = c_alloc[NUM_FLIT];
  assign bus.out_deflect = c_deflect[NUM_FLIT];
  assign bus.out_nogrant = c_nogrant[NUM_FLIT];
  assign bus.deflect_cnt = cnt;

  // Counts the batch currently on the outputs; clear wins over the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (bus.cnt_clr)      cnt <= '0;
    else if (bus.out_valid)    cnt <= sat_add(cnt, popcount(bus.out_deflect));
  end

endmodule

// File: tb/tb_port_alloc_pipe.sv
// Table-driven scoreboard bench for port_alloc_pipe, with a 16-bit and a
// 2-bit counter instance fed the same batches.
module tb_port_alloc_pipe;
  import port_alloc_pipe_pkg::*;

  localparam int NP = 5;
  localparam int NF = 4;

  typedef struct packed {
    logic             valid;
    logic [NF-1:0]    fvld;
    logic [NF*NP-1:0] req;
    logic [NP-1:0]    avail;
    logic [NF*NP-1:0] alloc;
    logic [NF-1:0]    defl;
    logic [NF-1:0]    nog;
  } vec_t;

  typedef struct packed {
    logic             valid;
    logic [NF*NP-1:0] alloc;
    logic [NF-1:0]    defl;
    logic [NF-1:0]    nog;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t q[$];
  exp_t shown;
  int   e16;
  int   e2;
  vec_t tbl[9];
  vec_t bub;

  port_alloc_pipe_if #(.NUM_PORT(NP), .NUM_FLIT(NF), .CNT_W(16)) bus ();
  port_alloc_pipe_if #(.NUM_PORT(NP), .NUM_FLIT(NF), .CNT_W(2))  bus_s ();

  assign bus_s.in_valid    = bus.in_valid;
  assign bus_s.in_flit_vld = bus.in_flit_vld;
  assign bus_s.in_req      = bus.in_req;
  assign bus_s.in_avail    = bus.in_avail;
  assign bus_s.cnt_clr     = bus.cnt_clr;

  port_alloc_pipe #(.NUM_PORT(NP), .NUM_FLIT(NF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  port_alloc_pipe #(.NUM_PORT(NP), .NUM_FLIT(NF), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] f,
                              input logic [4:0] r3, r2, r1, r0, input logic [4:0] av,
                              input logic [4:0] a3, a2, a1, a0,
                              input logic [3:0] d, input logic [3:0] n);
    vec_t r;
    r.valid = v;
    r.fvld  = f;
    r.req   = {r3, r2, r1, r0};
    r.avail = av;
    r.alloc = {a3, a2, a1, a0};
    r.defl  = d;
    r.nog   = n;
    return r;
  endfunction

  function automatic int popcnt(input logic [NF-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NF; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid",   32'(bus.out_valid),     32'(shown.valid));
    chk("out_alloc",   32'(bus.out_alloc),     32'(shown.alloc));
    chk("out_deflect", 32'(bus.out_deflect),   32'(shown.defl));
    chk("out_nogrant", 32'(bus.out_nogrant),   32'(shown.nog));
    chk("sat_alloc",   32'(bus_s.out_alloc),   32'(shown.alloc));
    chk("cnt16",       32'(bus.deflect_cnt),   32'(e16));
    chk("cnt2",        32'(bus_s.deflect_cnt), 32'(e2));
  endtask

  task automatic step(input vec_t v, input logic clr);
    int pc;
    bus.in_valid    = v.valid;
    bus.in_flit_vld = v.fvld;
    bus.in_req      = v.req;
    bus.in_avail    = v.avail;
    bus.cnt_clr     = clr;
    q.push_back({v.valid, v.alloc, v.defl, v.nog});
    pc = shown.valid ? popcnt(shown.defl) : 0;
    if (clr) begin
      e16 = 0;
      e2  = 0;
    end else begin
      e16 = (e16 + pc > 65535) ? 65535 : e16 + pc;
      e2  = (e2 + pc > 3) ? 3 : e2 + pc;
    end
    @(posedge clk);
    @(negedge clk);
    if (q.size() > NF) shown = q.pop_front();
    else               shown = '0;
    check_outputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e16    = 0;
    e2     = 0;
    shown  = '0;
    bub    = mk(1'b0, 4'b1111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111,
                '0, '0, '0, '0, 4'b0000, 4'b0000);

    // straight, contention, rotation, bubble, scarcity, partial valid,
    // highest-bit pick, wrap-around, nothing available
    tbl[0] = mk(1, 4'b1111, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b11111,
                5'b01000, 5'b00100, 5'b00010, 5'b00001, 4'b0000, 4'b0000);
    tbl[1] = mk(1, 4'b1111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111,
                5'b00100, 5'b00010, 5'b00001, 5'b10000, 4'b1110, 4'b0000);
    tbl[2] = mk(1, 4'b1111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111,
                5'b01000, 5'b00100, 5'b00010, 5'b10000, 4'b1110, 4'b0000);
    tbl[3] = bub;
    tbl[4] = mk(1, 4'b1111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00011,
                5'b00000, 5'b00000, 5'b00010, 5'b00001, 4'b0011, 4'b1100);
    tbl[5] = mk(1, 4'b1010, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111,
                5'b00001, 5'b00000, 5'b10000, 5'b00000, 4'b1000, 4'b0000);
    tbl[6] = mk(1, 4'b1111, 5'b00000, 5'b00011, 5'b00011, 5'b01011, 5'b11111,
                5'b00100, 5'b00001, 5'b00010, 5'b01000, 4'b1000, 4'b0000);
    tbl[7] = mk(1, 4'b0001, 5'b11111, 5'b11111, 5'b11111, 5'b00010, 5'b00001,
                5'b00000, 5'b00000, 5'b00000, 5'b00001, 4'b0001, 4'b0000);
    tbl[8] = mk(1, 4'b0011, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000,
                5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'b0000, 4'b0011);

    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_flit_vld = '0;
    bus.in_req      = '0;
    bus.in_avail    = '0;
    bus.cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;

    for (int i = 0; i < 9; i++) step(tbl[i], 1'b0);
    for (int i = 0; i < NF + 1; i++) step(bub, 1'b0);
    chk("cnt16_total", 32'(bus.deflect_cnt), 32'd11);
    chk("cnt2_saturated", 32'(bus_s.deflect_cnt), 32'd3);

    // Asynchronous reset with batches still in flight.
    for (int i = 0; i < 6; i++) step(tbl[0], 1'b0);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid",   32'(bus.out_valid),     32'd0);
    chk("rst_out_alloc",   32'(bus.out_alloc),     32'd0);
    chk("rst_out_deflect", 32'(bus.out_deflect),   32'd0);
    chk("rst_out_nogrant", 32'(bus.out_nogrant),   32'd0);
    chk("rst_cnt16",       32'(bus.deflect_cnt),   32'd0);
    chk("rst_cnt2",        32'(bus_s.deflect_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    shown = '0;
    e16   = 0;
    e2    = 0;

    for (int i = 0; i < NF + 2; i++) step(bub, 1'b0);
    step(tbl[1], 1'b0);
    step(tbl[4], 1'b0);
    for (int i = 0; i < NF + 3; i++)
      step(bub, shown.valid && (popcnt(shown.defl) == 2));
    chk("cnt16_after_clr", 32'(bus.deflect_cnt),   32'd0);
    chk("cnt2_after_clr",  32'(bus_s.deflect_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_alloc_pipe.md
# port_alloc_pipe

Parametrised, pipelined last-stage port allocator for the bufferless deflection router. Each cycle it accepts one batch of up to NUM_FLIT priority-ordered flits, flit 0 being oldest/highest priority. Flits are granted output ports one per pipeline stage, so every flit gets either a productive port or a deflection port. Deflection ports are chosen round-robin per stage, not fixed-highest, and the block keeps a saturating deflection counter for the router statistics path.

## Interface
- NUM_PORT, 5, number of output ports; bit i of every port vector is port i.
- NUM_FLIT, 4, flits per batch and number of pipeline stages; NUM_FLIT <= NUM_PORT.
- CNT_W, 16, width of the deflection counter.
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  batch present this cycle.
- in_flit_vld  input  NUM_FLIT  per-flit valid; bit k is flit k.
- in_req  input  NUM_FLIT*NUM_PORT  productive-port request; flit k uses bits [k*NUM_PORT +: NUM_PORT].
- in_avail  input  NUM_PORT  ports free for this batch.
- cnt_clr  input  1  synchronous clear of deflect_cnt.
- out_valid  output  1  batch result present.
- out_alloc  output  NUM_FLIT*NUM_PORT  one-hot grant per flit, or zero.
- out_deflect  output  NUM_FLIT  flit k was granted a non-requested port.
- out_nogrant  output  NUM_FLIT  valid flit k got no port.
- deflect_cnt  output  CNT_W  saturating count of deflected flits.

## Operation
- Stage k (k = 0..NUM_FLIT-1) allocates flit k against the availability vector handed on by stage k-1. Stage 0 receives in_avail.
- Invalid flit, or batch not valid: alloc 0, deflect 0, nogrant 0; availability passes through unchanged.
- Productive: if req_k & avail_k is nonzero, alloc = highest set bit of req_k & avail_k; deflect 0.
- Deflect: else if avail_k is nonzero, alloc = first set bit of avail_k scanning upward from ptr_k and wrapping past NUM_PORT-1 to 0; deflect 1; ptr_k <= (granted index + 1) mod NUM_PORT. ptr_k changes only on a deflection in a valid batch.
- No port: else alloc 0, nogrant 1, deflect 0.
- Availability out of stage k = avail_k & ~alloc_k.
- Grants for flit k are carried alongside the batch through the remaining stages, so all flits of one batch exit together.
- deflect_cnt adds popcount(out_deflect) whenever out_valid is 1 and saturates at 2^CNT_W-1.
- cnt_clr takes priority: that cycle deflect_cnt <= 0 and the same-cycle increment is discarded.

## Timing
- Fully pipelined; one batch per cycle, no back-pressure.
- Latency NUM_FLIT cycles: a batch sampled at edge t appears on the outputs after edge t+NUM_FLIT.
- All outputs registered.
- On reset assertion, asynchronously and regardless of clk:
  - out_valid, out_alloc, out_deflect, out_nogrant = 0;
  - all stage valids = 0;
  - all ptr_k = 0;
  - deflect_cnt = 0.
- Reset mid-operation drops in-flight batches silently; the first batch sampled after deassertion is the first one output.
- A bubble (in_valid 0) propagates as out_valid 0 with all flit outputs 0; pointers and counter unchanged.
- Invariant: within one batch out_alloc vectors are pairwise disjoint and each is a subset of in_avail.

## Structure
- Shared package/global include: NUM_PORT and NUM_FLIT defaults, CNT_W, and a port-vector width macro alongside the existing `NUM_PORT.
- Sub-module port_alloc_stage:
  - one stage: combinational productive/round-robin pick, its own ptr register, and pipeline registers for avail, remaining req/vld and accumulated grants;
  - the top instantiates NUM_FLIT of them with a generate loop and adds the counter.
- Reuse the existing highest-bit priority encoder for the productive pick.

## Test plan
- NUM_PORT=5, NUM_FLIT=4; avail=5'b11111; flit reqs 5'b00001, 5'b00010, 5'b00100, 5'b01000 -> grants equal reqs, deflect 0000, out_valid exactly 4 cycles after in_valid.
- Contention: all 4 flits req 5'b10000, avail 5'b11111, pointers 0 -> flit0 gets 10000; flits 1,2,3 deflect to 00001, 00010, 00100; deflect_cnt += 3.
- Pointer rotation: repeat the previous batch -> stage1 ptr is now 1, so flit1 deflects to 00010; stage2 ptr is now 2, so flit2 deflects to 00100. Back-to-back batches each cycle stay independent.
- Scarcity: avail=5'b00011, 4 valid flits all req 5'b10000 -> flits 0,1 deflect to 00001, 00010; flits 2,3 nogrant=1, alloc 0.
- Counter: CNT_W=2; force 4 deflections -> cnt stays 3. cnt_clr in the same cycle as a 2-deflection output -> cnt 0.
- Reset: assert reset mid-stream with 3 batches in flight -> all outputs 0 immediately with no clk edge; no stale batch emerges after deassertion; ptrs restart at 0.
